// File: rtl/memory_access_unit.sv
// memory_access_unit
// Memory-access stage of the SimpleRISC pipeline. It accepts one execute
// bundle at a time, performs the load or store through a req/ack data-memory
// port, and then presents a registered bundle to write-back for one cycle.
// Faults are reported as a flagged completion that never writes back. Two
// kinds of fault exist: an address beyond ADDR_W bits, and a memory that does
// not ack within TIMEOUT request cycles.
//
// Ports
//   clk, reset                 clock; synchronous active-high reset
//   in_valid / in_ready        execute handshake (ready only in IDLE)
//   aluResult, op2, pc,
//   instruction, isLd, isSt,
//   isCall, isWb               incoming bundle
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_rdata,
//   mem_ack                    data-memory handshake
//   out_valid, mem_err         one-cycle completion / fault pulses
//   aluResult_out, ldResult,
//   pc_out, instruction_out,
//   isLd_out, isCall_out,
//   isWb_out                   registered bundle to write-back
module memory_access_unit #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       aluResult,
  input  logic [31:0]       op2,
  input  logic [31:0]       pc,
  input  logic [31:0]       instruction,
  input  logic              isLd,
  input  logic              isSt,
  input  logic              isCall,
  input  logic              isWb,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              out_valid,
  output logic [31:0]       aluResult_out,
  output logic [31:0]       ldResult,
  output logic [31:0]       pc_out,
  output logic [31:0]       instruction_out,
  output logic              isLd_out,
  output logic              isCall_out,
  output logic              isWb_out,
  output logic              mem_err
);

  // The counter runs 0..TIMEOUT-1, one count per unacked request cycle.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t r_state, w_next;

  logic              w_is_mem;
  logic              w_range_ok;
  logic              w_cnt_last;
  logic [CNT_W-1:0]  r_cnt;

  // Bundle captured at accept, held while the access is in flight.
  logic [31:0]       r_alu_q, r_pc_q, r_instr_q;
  logic              r_isLd_q, r_isCall_q, r_isWb_q;

  // Memory request registers, stable for the whole ACCESS phase.
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [31:0]       r_mem_wdata;

  // Published bundle: only rewritten on entry to DONE, so it holds between
  // completions.
  logic [31:0]       r_alu_out, r_ld_out, r_pc_out, r_instr_out;
  logic              r_isLd_out, r_isCall_out, r_wb_out, r_err;

  assign w_is_mem   = isLd | isSt;
  assign w_range_ok = ~|aluResult[31:ADDR_W];
  assign w_cnt_last = (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (in_valid) w_next = (w_is_mem && w_range_ok) ? S_ACCESS : S_DONE;
      // Ack is checked first so an ack on the last allowed cycle still wins.
      S_ACCESS: if (mem_ack || w_cnt_last) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_alu_q      <= '0;
      r_pc_q       <= '0;
      r_instr_q    <= '0;
      r_isLd_q     <= 1'b0;
      r_isCall_q   <= 1'b0;
      r_isWb_q     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_we     <= 1'b0;
      r_mem_wdata  <= '0;
      r_alu_out    <= '0;
      r_ld_out     <= '0;
      r_pc_out     <= '0;
      r_instr_out  <= '0;
      r_isLd_out   <= 1'b0;
      r_isCall_out <= 1'b0;
      r_wb_out     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_alu_q    <= aluResult;
            r_pc_q     <= pc;
            r_instr_q  <= instruction;
            r_isLd_q   <= isLd;
            r_isCall_q <= isCall;
            r_isWb_q   <= isWb;
            if (w_is_mem && w_range_ok) begin
              r_mem_addr  <= aluResult[ADDR_W-1:0];
              // A bundle flagged as both load and store is treated as a load.
              r_mem_we    <= isSt & ~isLd;
              r_mem_wdata <= op2;
              r_cnt       <= '0;
            end else begin
              // No memory access needed: publish straight from the inputs.
              // A memory op reaching here is an out-of-range fault.
              r_alu_out    <= aluResult;
              r_pc_out     <= pc;
              r_instr_out  <= instruction;
              r_isLd_out   <= isLd;
              r_isCall_out <= isCall;
              r_ld_out     <= '0;
              r_wb_out     <= isWb & ~w_is_mem;
              r_err        <= w_is_mem;
            end
          end
        end
        S_ACCESS: begin
          if (mem_ack || w_cnt_last) begin
            r_alu_out    <= r_alu_q;
            r_pc_out     <= r_pc_q;
            r_instr_out  <= r_instr_q;
            r_isLd_out   <= r_isLd_q;
            r_isCall_out <= r_isCall_q;
            r_ld_out     <= (mem_ack && !r_mem_we) ? mem_rdata : 32'd0;
            r_wb_out     <= mem_ack & r_isWb_q;
            r_err        <= ~mem_ack;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready        = (r_state == S_IDLE);
  assign mem_req         = (r_state == S_ACCESS);
  assign mem_we          = r_mem_we;
  assign mem_addr        = r_mem_addr;
  assign mem_wdata       = r_mem_wdata;
  assign out_valid       = (r_state == S_DONE);
  assign mem_err         = (r_state == S_DONE) & r_err;
  assign isWb_out        = (r_state == S_DONE) & r_wb_out;
  assign aluResult_out   = r_alu_out;
  assign ldResult        = r_ld_out;
  assign pc_out          = r_pc_out;
  assign instruction_out = r_instr_out;
  assign isLd_out        = r_isLd_out;
  assign isCall_out      = r_isCall_out;

endmodule

// File: tb/tb_memory_access_unit.sv
// Testbench for memory_access_unit: table of directed bundles with a small
// bench-side memory that acks on a chosen request cycle, plus a hand-written
// reset-during-access sequence.
module tb_memory_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] aluResult, op2, pc, instruction;
  logic        isLd, isSt, isCall, isWb;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        out_valid;
  logic [31:0] aluResult_out, ldResult, pc_out, instruction_out;
  logic        isLd_out, isCall_out, isWb_out, mem_err;

  int n_total = 0;
  int n_pass  = 0;

  memory_access_unit #(.ADDR_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .aluResult(aluResult), .op2(op2), .pc(pc), .instruction(instruction),
    .isLd(isLd), .isSt(isSt), .isCall(isCall), .isWb(isWb),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .out_valid(out_valid), .aluResult_out(aluResult_out), .ldResult(ldResult),
    .pc_out(pc_out), .instruction_out(instruction_out), .isLd_out(isLd_out),
    .isCall_out(isCall_out), .isWb_out(isWb_out), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] alu, op2, pc, instr, rdata;
    logic        ld, st, call, wb;
    int          ack_at;     // request cycle on which memory acks; 0 = never
    int          exp_lat;    // cycles from accept edge to out_valid
    int          exp_reqs;   // number of mem_req cycles
    logic [31:0] exp_ld;
    logic        exp_err, exp_wb, exp_we;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   reqs;
    int   lat;
    bit   done;
    bit   addr_ok;
    logic [31:0] alu_seen, ld_seen;
    reqs = 0; lat = 0; done = 0; addr_ok = 1;
    @(negedge clk);
    chk($sformatf("v%0d ready", idx), {31'd0, in_ready}, 32'd1);
    aluResult = v.alu; op2 = v.op2; pc = v.pc; instruction = v.instr;
    isLd = v.ld; isSt = v.st; isCall = v.call; isWb = v.wb;
    in_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 20 && !done; c++) begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 32'hBADB_AD00;
      if (mem_req) begin
        reqs++;
        if (mem_addr !== v.alu[15:0] || mem_we !== v.exp_we || mem_wdata !== v.op2)
          addr_ok = 0;
        if (reqs == v.ack_at) begin
          mem_ack   = 1'b1;
          mem_rdata = v.rdata;
        end
      end
      if (out_valid) begin
        done = 1;
        lat  = c;
        in_valid = 1'b0;
        chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d reqs", idx), reqs, v.exp_reqs);
        chk($sformatf("v%0d ldResult", idx), ldResult, v.exp_ld);
        chk($sformatf("v%0d aluResult_out", idx), aluResult_out, v.alu);
        chk($sformatf("v%0d pc_out", idx), pc_out, v.pc);
        chk($sformatf("v%0d instruction_out", idx), instruction_out, v.instr);
        chk($sformatf("v%0d isLd_out", idx), {31'd0, isLd_out}, {31'd0, v.ld});
        chk($sformatf("v%0d isCall_out", idx), {31'd0, isCall_out}, {31'd0, v.call});
        chk($sformatf("v%0d isWb_out", idx), {31'd0, isWb_out}, {31'd0, v.exp_wb});
        chk($sformatf("v%0d mem_err", idx), {31'd0, mem_err}, {31'd0, v.exp_err});
        chk($sformatf("v%0d in_ready_busy", idx), {31'd0, in_ready}, 32'd0);
        if (v.exp_reqs > 0)
          chk($sformatf("v%0d mem_port", idx), {31'd0, addr_ok}, 32'd1);
      end else begin
        // Junk bundle offered while busy; it must not be taken.
        in_valid = 1'b1;
        aluResult = 32'hBAD0_0BAD; op2 = 32'h0BAD_0BAD; pc = 32'hFFFF_FFFC;
        instruction = 32'hFFFF_FFFF; isLd = 1'b1; isSt = 1'b1; isCall = 1'b1; isWb = 1'b1;
      end
    end
    if (!done) chk($sformatf("v%0d out_valid_timeout", idx), 32'd0, 32'd1);
    alu_seen = aluResult_out;
    ld_seen  = ldResult;
    @(negedge clk);
    chk($sformatf("v%0d pulse_end", idx), {29'd0, out_valid, mem_err, isWb_out}, 32'd0);
    chk($sformatf("v%0d ready_again", idx), {31'd0, in_ready}, 32'd1);
    chk($sformatf("v%0d hold", idx), {aluResult_out ^ alu_seen} | {ldResult ^ ld_seen}, 32'd0);
  endtask

  initial begin
    int stray;
    // alu, op2, pc, instr, rdata, ld, st, call, wb, ack_at, lat, reqs, exp_ld, err, wb, we
    vecs[0] = '{32'h0000_00F0, 32'h0, 32'h0000_0100, 32'h0240_0000, 32'h0,
                1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 0, 32'h0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{32'h0000_0010, 32'h0, 32'h0000_0104, 32'h1234_0001, 32'hF0F0_F0F1,
                1'b1, 1'b0, 1'b0, 1'b1, 3, 4, 3, 32'hF0F0_F0F1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_0004, 32'hDEAD_BEEF, 32'h0000_0108, 32'h1234_0002, 32'h0,
                1'b0, 1'b1, 1'b0, 1'b0, 1, 2, 1, 32'h0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'h0001_0000, 32'h0, 32'h0000_010C, 32'h1234_0003, 32'h0,
                1'b1, 1'b0, 1'b0, 1'b1, 1, 1, 0, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_0020, 32'h0, 32'h0000_0110, 32'h1234_0004, 32'h0,
                1'b1, 1'b0, 1'b0, 1'b1, 0, 9, 8, 32'h0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{32'h0000_0030, 32'h0, 32'h0000_0114, 32'h1234_0005, 32'h1234_5678,
                1'b1, 1'b0, 1'b0, 1'b1, 8, 9, 8, 32'h1234_5678, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{32'h0000_0044, 32'h0, 32'h0000_0020, 32'h1234_0006, 32'h0,
                1'b0, 1'b0, 1'b1, 1'b1, 0, 1, 0, 32'h0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{32'h0000_0008, 32'h0000_AAAA, 32'h0000_0118, 32'h1234_0007, 32'h0000_0055,
                1'b1, 1'b1, 1'b0, 1'b1, 2, 3, 2, 32'h0000_0055, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{32'hFFFF_0000, 32'h1111_2222, 32'h0000_011C, 32'h1234_0008, 32'h0,
                1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 0, 32'h0, 1'b1, 1'b0, 1'b0};

    reset = 1'b1; in_valid = 1'b0; aluResult = '0; op2 = '0; pc = '0; instruction = '0;
    isLd = 1'b0; isSt = 1'b0; isCall = 1'b0; isWb = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset flags", {26'd0, mem_req, mem_we, out_valid, mem_err, isWb_out, isLd_out}, 32'd0);
    chk("reset bundle", aluResult_out | ldResult | pc_out | instruction_out, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Reset during ACCESS, then a stray ack that must be ignored.
    @(negedge clk);
    aluResult = 32'h0000_0040; isLd = 1'b1; isSt = 1'b0; isWb = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid-access req", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst bundle", aluResult_out | ldResult | pc_out, 32'd0);
    reset = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    stray = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid || !in_ready || mem_req) stray++;
    end
    chk("stray ack ignored", stray, 0);
    mem_ack = 1'b0;

    run_vec(vecs[1], 9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
